pulse_period_meter: RTL

//  Measures the interval, in clk cycles, between consecutive rising edges of a

---
 rtl/pulse_period_meter_pkg.sv | 15 +
 rtl/pulse_period_meter_sync_edge_detect.sv | 33 +++
 rtl/pulse_period_meter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pulse_period_meter_pkg.sv
// Shared helpers for the pulse period meter.
//   wordlength(): number of bits needed to represent a non-negative value
//   (minimum 1). Sizes the timeout comparator so the limit constants fit.
package pulse_period_meter_pkg;

  function automatic int unsigned wordlength(input longint unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 64; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_period_meter_sync_edge_detect.sv
// Synchroniser plus rising-edge detector for an asynchronous strobe.
// All flops reset to 1, so a pin already high at reset release does not
// produce an edge; the pin has to go low and then high again.
// Ports:
//   clk      clock
//   reset    asynchronous, active-high reset
//   pulse_i  asynchronous strobe
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the number of clk cycles between consecutive rising edges of a
// periodic strobe, flags a missing strobe with a sticky timeout.
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   turbosim      selects the short simulation timeout
//   en            measurement enable
//   pulse_in      strobe to measure (asynchronous to clk)
//   period        last measured period in clk cycles (holds)
//   period_valid  one-cycle strobe when period is updated
//   timeout       sticky: no edge inside the timeout window
//   busy          high while measuring
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT          = 50000,
  parameter int unsigned TIMEOUT_TURBOSIM = 20,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   turbosim,
  input  logic                   en,
  input  logic                   pulse_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  output logic                   timeout,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  localparam int unsigned T_MAX  = (TIMEOUT > TIMEOUT_TURBOSIM) ? TIMEOUT : TIMEOUT_TURBOSIM;
  localparam int unsigned T_W    = wordlength(longint'(T_MAX));
  // Comparator is wide enough for both the counter and the limit constants.
  localparam int unsigned CMP_W  = (T_W > COUNT_WIDTH) ? T_W : COUNT_WIDTH;
  localparam logic [CMP_W-1:0] T_NORM  = CMP_W'(TIMEOUT);
  localparam logic [CMP_W-1:0] T_TURBO = CMP_W'(TIMEOUT_TURBOSIM);

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] period_q;
  logic                   period_valid_q;
  logic                   timeout_q;
  logic                   busy_q;

  logic                   rise;
  logic [CMP_W-1:0]       t_eff;
  logic                   at_limit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pulse_i(pulse_in),
    .rise_o (rise)
  );

  always_comb begin
    t_eff    = turbosim ? T_TURBO : T_NORM;
    at_limit = (CMP_W'(cnt_q) == t_eff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (!en) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ARM;
            busy_q  <= 1'b0;
          end
          ST_ARM: begin
            if (rise) begin
              cnt_q   <= COUNT_WIDTH'(1);
              state_q <= ST_MEASURE;
              busy_q  <= 1'b1;
            end
          end
          ST_MEASURE: begin
            // An edge landing on the limit cycle still counts as a period.
            if (rise) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              timeout_q      <= 1'b0;
              cnt_q          <= COUNT_WIDTH'(1);
            end else if (at_limit) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ST_ARM;
              busy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule
